// File: rtl/seven_seg_time_display.sv
// ---------------------------------------------------------------------------
// seven_seg_time_display
//
// Drives a 4-digit common-anode 7-segment display as HH.MM from binary
// hour/minute. Inputs are snapshotted once per scan frame (on the refresh
// tick that leaves the hour-tens slot). A small subtract-10 FSM then converts
// them to BCD, so the display never tears mid-frame.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 16)
//   BLINK_DIV    clk cycles per blink half-period (>= 2)
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous, active-high reset
//   hour    in   [4:0] binary hour, 0..23 valid (others shown as dashes)
//   minute  in   [6:0] binary minute, 0..59 valid (others shown as dashes)
//   blink   in   [3:0] per-digit blink enable, bit i controls an[i]
//   an      out  [3:0] digit enables, active-low (an[3] = hour tens)
//   seg     out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp      out  decimal point, active-low, lit on the hour-ones digit
//
// Optional build macro:
//   LEADING_ZERO_BLANK_EN  blank the hour-tens digit when it is a valid zero
// ---------------------------------------------------------------------------
module seven_seg_time_display #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLINK_DIV   = 12500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] hour,
    input  logic [6:0] minute,
    input  logic [3:0] blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned REF_W = $clog2(REFRESH_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE,
        CONV_H,
        CONV_M,
        LOAD
    } state_t;

    state_t           state_q, state_d;

    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_tick;
    logic [1:0]       idx_q, idx_d;
    logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
    logic             blink_phase_q, blink_phase_d;

    logic [4:0]       h_rem_q, h_rem_d;
    logic [6:0]       m_rem_q, m_rem_d;
    logic [4:0]       snap_h_q, snap_h_d;
    logic [6:0]       snap_m_q, snap_m_d;
    logic [1:0]       h_tens_q, h_tens_d;
    logic [3:0]       m_tens_q, m_tens_d;

    logic [3:0]       dh1_q, dh1_d;
    logic [3:0]       dh0_q, dh0_d;
    logic [3:0]       dm1_q, dm1_d;
    logic [3:0]       dm0_q, dm0_d;
    logic             h_bad_q, h_bad_d;
    logic             m_bad_q, m_bad_d;

    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic [3:0]       digit;
    logic             digit_bad;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Refresh and blink timebases
    always_comb begin
        ref_tick      = (ref_cnt_q == REF_LAST);
        ref_cnt_d     = ref_tick ? '0 : ref_cnt_q + REF_W'(1);
        idx_d         = ref_tick ? idx_q + 2'd1 : idx_q;
        blk_cnt_d     = (blk_cnt_q == BLK_LAST) ? '0 : blk_cnt_q + BLK_W'(1);
        blink_phase_d = (blk_cnt_q == BLK_LAST) ? ~blink_phase_q : blink_phase_q;
    end

    // Snapshot + binary-to-BCD FSM
    always_comb begin
        state_d  = state_q;
        h_rem_d  = h_rem_q;
        m_rem_d  = m_rem_q;
        snap_h_d = snap_h_q;
        snap_m_d = snap_m_q;
        h_tens_d = h_tens_q;
        m_tens_d = m_tens_q;
        dh1_d    = dh1_q;
        dh0_d    = dh0_q;
        dm1_d    = dm1_q;
        dm0_d    = dm0_q;
        h_bad_d  = h_bad_q;
        m_bad_d  = m_bad_q;

        case (state_q)
            IDLE: begin
                if (ref_tick && (idx_q == 2'd3)) begin
                    h_rem_d  = hour;
                    m_rem_d  = minute;
                    snap_h_d = hour;
                    snap_m_d = minute;
                    h_tens_d = '0;
                    m_tens_d = '0;
                    state_d  = CONV_H;
                end
            end
            // Leave as soon as the remainder after this step is below 10, so
            // the worst case (31/127) is 3+12+1 cycles instead of 3+1+12+1+1.
            CONV_H: begin
                if (h_rem_q >= 5'd10) begin
                    h_rem_d  = h_rem_q - 5'd10;
                    h_tens_d = h_tens_q + 2'd1;
                end
                if (h_rem_q < 5'd20) begin
                    state_d = CONV_M;
                end
            end
            CONV_M: begin
                if (m_rem_q >= 7'd10) begin
                    m_rem_d  = m_rem_q - 7'd10;
                    m_tens_d = m_tens_q + 4'd1;
                end
                if (m_rem_q < 7'd20) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dh1_d   = {2'b00, h_tens_q};
                dh0_d   = h_rem_q[3:0];
                dm1_d   = m_tens_q;
                dm0_d   = m_rem_q[3:0];
                h_bad_d = (snap_h_q > 5'd23);
                m_bad_d = (snap_m_q > 7'd59);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Digit mux, decode, blanking
    always_comb begin
        case (idx_q)
            2'd0:    digit = dm0_q;
            2'd1:    digit = dm1_q;
            2'd2:    digit = dh0_q;
            default: digit = dh1_q;
        endcase
        digit_bad = idx_q[1] ? h_bad_q : m_bad_q;

        seg_d = digit_bad ? SEG_DASH : seg_decode(digit);
        an_d  = ~(4'b0001 << idx_q);
        dp_d  = (idx_q != 2'd2);

        if (blink[idx_q] && blink_phase_q) begin
            an_d = '1;
            dp_d = 1'b1;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if ((idx_q == 2'd3) && (dh1_q == 4'd0) && !h_bad_q) begin
            an_d = '1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ref_cnt_q     <= '0;
            idx_q         <= '0;
            blk_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
            h_rem_q       <= '0;
            m_rem_q       <= '0;
            snap_h_q      <= '0;
            snap_m_q      <= '0;
            h_tens_q      <= '0;
            m_tens_q      <= '0;
            dh1_q         <= '0;
            dh0_q         <= '0;
            dm1_q         <= '0;
            dm0_q         <= '0;
            h_bad_q       <= 1'b0;
            m_bad_q       <= 1'b0;
            an_q          <= '1;
            seg_q         <= '1;
            dp_q          <= 1'b1;
        end else begin
            state_q       <= state_d;
            ref_cnt_q     <= ref_cnt_d;
            idx_q         <= idx_d;
            blk_cnt_q     <= blk_cnt_d;
            blink_phase_q <= blink_phase_d;
            h_rem_q       <= h_rem_d;
            m_rem_q       <= m_rem_d;
            snap_h_q      <= snap_h_d;
            snap_m_q      <= snap_m_d;
            h_tens_q      <= h_tens_d;
            m_tens_q      <= m_tens_d;
            dh1_q         <= dh1_d;
            dh0_q         <= dh0_d;
            dm1_q         <= dm1_d;
            dm0_q         <= dm0_d;
            h_bad_q       <= h_bad_d;
            m_bad_q       <= m_bad_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_time_display.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_time_display
//
// Bench for seven_seg_time_display with REFRESH_DIV=16, BLINK_DIV=256.
// cyc counts rising edges since the last reset release; after edge k the
// output register shows slot ((k-1)/16)%4 and blink phase ((k-1)/256)%2.
// Expected slot contents are queued with their sample cycle and compared by
// a negedge monitor when that cycle arrives.
// ---------------------------------------------------------------------------
module tb_seven_seg_time_display;

    localparam int unsigned FR = 64;  // clk cycles per scan frame

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic [4:0] hour   = '0;
    logic [6:0] minute = '0;
    logic [3:0] blink  = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int          n_checks = 0;
    int          n_pass   = 0;
    int unsigned cyc      = 0;

    typedef struct {
        int unsigned cyc;
        int          tag;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        chk_seg;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [4:0] hour;
        logic [6:0] minute;
        logic [6:0] ht, ho, mt, mo;
    } vec_t;

    vec_t vt[10];

    seven_seg_time_display #(
        .REFRESH_DIV(16),
        .BLINK_DIV  (256)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .hour  (hour),
        .minute(minute),
        .blink (blink),
        .an    (an),
        .seg   (seg),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                n_checks++;
                if (e.cyc != cyc)
                    $display("FAIL chk%0d: sample cycle %0d missed (now %0d)", e.tag, e.cyc, cyc);
                else if (an !== e.an || dp !== e.dp || (e.chk_seg && seg !== e.seg))
                    $display("FAIL chk%0d @%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b (seg checked=%0d)",
                             e.tag, cyc, an, seg, dp, e.an, e.seg, e.dp, e.chk_seg);
                else
                    n_pass++;
            end
        end
    end

    task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, got, exp);
    endtask

    task automatic push_slot(input int unsigned k, input int unsigned i, input logic [6:0] s,
                             input logic [3:0] bl, input bit lz, input int tag);
        exp_t       e;
        logic [3:0] one_hot;
        bit         blank;
        one_hot = 4'b0001 << i;
        blank   = bl[i] && ((((k - 1) / 256) % 2) == 1);
        if (LZB && i == 3 && lz) blank = 1'b1;
        e.cyc     = k;
        e.tag     = tag;
        e.an      = blank ? 4'b1111 : ~one_hot;
        e.seg     = s;
        e.dp      = blank ? 1'b1 : (i != 2);
        e.chk_seg = !blank;
        sb.push_back(e);
    endtask

    // Queue the mid-slot samples of frame f for slots selected by mask
    task automatic push_frame(input int unsigned f, input logic [6:0] ht, input logic [6:0] ho,
                              input logic [6:0] mt, input logic [6:0] mo, input logic [3:0] bl,
                              input bit lz, input logic [3:0] mask, input int tag);
        logic [6:0] s;
        for (int unsigned i = 0; i < 4; i++) begin
            case (i)
                0:       s = mo;
                1:       s = mt;
                2:       s = ho;
                default: s = ht;
            endcase
            if (mask[i]) push_slot(f * FR + 16 * i + 8, i, s, bl, lz, tag + int'(i));
        end
    endtask

    task automatic wait_cyc(input int unsigned k);
        int unsigned guard;
        guard = 0;
        if (cyc > k) begin
            n_checks++;
            $display("FAIL schedule: cycle %0d already passed (now %0d)", k, cyc);
        end
        while (cyc < k) begin
            @(negedge clk);
            guard++;
            if (guard > 20000) begin
                n_checks++;
                $display("FAIL wait_cyc: cycle %0d not reached, now %0d", k, cyc);
                $fatal(1, "clock stalled");
            end
        end
    endtask

    task automatic drain();
        int unsigned g;
        g = 0;
        while (sb.size() > 0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d queued samples never reached", sb.size());
            n_checks += sb.size();
            sb.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0;
        int unsigned f;
        int unsigned g;
        vec_t        old;

        vt[0] = '{5'd23, 7'd59,  S2,   S3,   S5,   S9};
        vt[1] = '{5'd9,  7'd60,  S0,   S9,   DASH, DASH};
        vt[2] = '{5'd9,  7'd0,   S0,   S9,   S0,   S0};
        vt[3] = '{5'd12, 7'd34,  S1,   S2,   S3,   S4};
        vt[4] = '{5'd24, 7'd7,   DASH, DASH, S0,   S7};
        vt[5] = '{5'd0,  7'd59,  S0,   S0,   S5,   S9};
        vt[6] = '{5'd18, 7'd26,  S1,   S8,   S2,   S6};
        vt[7] = '{5'd31, 7'd127, DASH, DASH, DASH, DASH};
        vt[8] = '{5'd16, 7'd40,  S1,   S6,   S4,   S0};
        vt[9] = '{5'd7,  7'd5,   S0,   S7,   S0,   S5};

        // Power-on reset
        repeat (3) @(negedge clk);
        chk("reset_an",  {3'b000, an}, 7'b0001111);
        chk("reset_seg", seg,          7'b1111111);
        chk("reset_dp",  {6'b0, dp},   7'b0000001);
        rst = 1'b0;
        push_frame(0, S0, S0, S0, S0, 4'b0000, 1'b1, 4'hF, 100);

        // Table: apply mid-frame, check the frame after the next reload
        for (int unsigned v = 0; v < 10; v++) begin
            f0 = cyc / FR + 1;
            wait_cyc(f0 * FR + 32);
            hour   = vt[v].hour;
            minute = vt[v].minute;
            push_frame(f0 + 2, vt[v].ht, vt[v].ho, vt[v].mt, vt[v].mo, 4'b0000,
                       vt[v].hour < 5'd10, 4'hF, 110 + int'(v) * 10);
            wait_cyc((f0 + 2) * FR + 60);
        end

        // Mid-frame change: old digits until reload, new ones by tick+17
        old = vt[9];
        f = cyc / FR + 1;
        wait_cyc(f * FR + 20);
        hour   = 5'd10;
        minute = 7'd42;
        push_frame(f, old.ht, old.ho, old.mt, old.mo, 4'b0000, old.hour < 5'd10, 4'b1110, 300);
        push_slot((f + 1) * FR + 17, 1, S4, 4'b0000, 1'b0, 310);
        push_frame(f + 1, S1, S0, S4, S2, 4'b0000, 1'b0, 4'b1100, 320);

        // Worst-case conversion 31/127 still lands by tick+17
        wait_cyc((f + 2) * FR + 20);
        hour   = 5'd31;
        minute = 7'd127;
        push_slot((f + 2) * FR + 56, 3, S1, 4'b0000, 1'b0, 330);
        push_slot((f + 3) * FR + 17, 1, DASH, 4'b0000, 1'b0, 340);
        push_frame(f + 3, DASH, DASH, DASH, DASH, 4'b0000, 1'b0, 4'b1100, 350);
        wait_cyc((f + 3) * FR + 60);
        drain();

        // Reset in the middle of a conversion
        hour   = 5'd23;
        minute = 7'd59;
        g = cyc / FR + 1;
        wait_cyc(g * FR + 5);
        rst = 1'b1;
        #1;
        chk("midrst_an",  {3'b000, an}, 7'b0001111);
        chk("midrst_seg", seg,          7'b1111111);
        chk("midrst_dp",  {6'b0, dp},   7'b0000001);
        @(negedge clk);
        chk("midrst_an2",  {3'b000, an}, 7'b0001111);
        chk("midrst_seg2", seg,          7'b1111111);
        chk("midrst_dp2",  {6'b0, dp},   7'b0000001);
        rst = 1'b0;
        push_frame(0, S0, S0, S0, S0, 4'b0000, 1'b1, 4'hF, 400);
        push_frame(2, S2, S3, S5, S9, 4'b0000, 1'b0, 4'hF, 410);
        wait_cyc(2 * FR + 60);

        // Blink on hour digits across both phases
        hour   = 5'd12;
        minute = 7'd34;
        blink  = 4'b1100;
        for (int unsigned fr = 5; fr < 13; fr++)
            push_frame(fr, S1, S2, S3, S4, 4'b1100, 1'b0, 4'hF, 500 + int'(fr) * 10);
        wait_cyc(13 * FR);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
